// File: rtl/rob_pkg.sv
// ----------------------------------------------------------------------------
// rob_pkg
// Shared types for the reorder buffer slice.
//   ROB_XLEN_MAX  : widest datapath supported by rob_entry_t. The top slices
//                   its XLEN bits out of these fields, so XLEN must be <= 64.
//   instr_type_e  : 3-bit instruction class carried through the ROB.
//   exception_e   : 3-bit exception code; EXC_NONE (0) means a clean result.
//   rob_entry_t   : one ROB slot (valid, complete, PC, miss address, value,
//                   destination register, exception, instruction type).
//   has_exception : true when an exception code is anything but EXC_NONE.
// ----------------------------------------------------------------------------
package rob_pkg;

    localparam int ROB_XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IT_ALU    = 3'd0,
        IT_LOAD   = 3'd1,
        IT_STORE  = 3'd2,
        IT_BRANCH = 3'd3,
        IT_JUMP   = 3'd4,
        IT_CSR    = 3'd5,
        IT_FENCE  = 3'd6,
        IT_SYSTEM = 3'd7
    } instr_type_e;

    typedef enum logic [2:0] {
        EXC_NONE     = 3'd0,
        EXC_MISALIGN = 3'd1,
        EXC_ACCESS   = 3'd2,
        EXC_ILLEGAL  = 3'd3,
        EXC_BREAK    = 3'd4,
        EXC_ECALL    = 3'd5,
        EXC_PAGE     = 3'd6,
        EXC_OTHER    = 3'd7
    } exception_e;

    typedef struct packed {
        logic                    valid;
        logic                    complete;
        logic [ROB_XLEN_MAX-1:0] pc;
        logic [ROB_XLEN_MAX-1:0] miss_addr;
        logic [ROB_XLEN_MAX-1:0] value;
        logic [4:0]              rd;
        logic [2:0]              exception;
        logic [2:0]              instr_type;
    } rob_entry_t;

    function automatic logic has_exception(input logic [2:0] exc);
        return exc != EXC_NONE;
    endfunction

endpackage

// File: rtl/rob_ptr_wrap.sv
// ----------------------------------------------------------------------------
// rob_ptr_wrap
// Increment-with-wrap for a ring pointer whose size need not be a power of
// two: SIZE-1 wraps back to 0.
//   ptr      in  W  current pointer (0..SIZE-1)
//   ptr_next out W  ptr+1, or 0 when ptr is the last slot
// ----------------------------------------------------------------------------
module rob_ptr_wrap #(
    parameter int SIZE = 10,
    parameter int W    = $clog2(SIZE)
) (
    input  logic [W-1:0] ptr,
    output logic [W-1:0] ptr_next
);

    assign ptr_next = (ptr == W'(SIZE - 1)) ? '0 : ptr + 1'b1;

endmodule

// File: rtl/reorder_buffer_mc.sv
// ----------------------------------------------------------------------------
// reorder_buffer_mc
// Circular reorder buffer with NUM_CPL completion ports and a zero-latency
// commit from the head entry. A committing head with a nonzero exception
// raises out_flush and empties the whole buffer on the next edge.
//
// Optional feature (macro ROB_DUAL_COMMIT_EN): commit slot 1 retires head+1
// in the same cycle as slot 0 when both are clean and complete. Without the
// macro slot 1 is tied off and at most one entry retires per cycle.
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   in_allocate, in_PC, in_addr_miss, in_rd, in_instr_type
//                                   tail allocation request and payload
//   in_complete[*], in_complete_idx[*], in_complete_value[*], in_exception[*]
//                                   completion ports; highest port wins
//   in_stall                        holds off commit this cycle
//   out_alloc_idx, out_alloc_ok     tail index / allocation accepted
//   out_full, out_empty, out_count  occupancy (from registered state)
//   out_ready[1:0] + payloads       commit slots 0 and 1, zero when not ready
//   out_flush                       head commits with an exception
// ----------------------------------------------------------------------------
module reorder_buffer_mc
    import rob_pkg::*;
#(
    parameter int  ROB_SIZE = 10,
    parameter int  NUM_CPL  = 2,
    parameter int  XLEN     = 32,
    localparam int IDX_W    = $clog2(ROB_SIZE),
    localparam int CNT_W    = $clog2(ROB_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_allocate,
    input  logic [XLEN-1:0]                 in_PC,
    input  logic [XLEN-1:0]                 in_addr_miss,
    input  logic [4:0]                      in_rd,
    input  logic [2:0]                      in_instr_type,
    input  logic [NUM_CPL-1:0]              in_complete,
    input  logic [NUM_CPL-1:0][IDX_W-1:0]   in_complete_idx,
    input  logic [NUM_CPL-1:0][XLEN-1:0]    in_complete_value,
    input  logic [NUM_CPL-1:0][2:0]         in_exception,
    input  logic                            in_stall,
    output logic [IDX_W-1:0]                out_alloc_idx,
    output logic                            out_alloc_ok,
    output logic                            out_full,
    output logic                            out_empty,
    output logic [CNT_W-1:0]                out_count,
    output logic [1:0]                      out_ready,
    output logic [1:0][XLEN-1:0]            out_value,
    output logic [1:0][XLEN-1:0]            out_PC,
    output logic [1:0][XLEN-1:0]            out_miss_addr,
    output logic [1:0][4:0]                 out_rd,
    output logic [1:0][2:0]                 out_exception,
    output logic [1:0][2:0]                 out_instr_type,
    output logic                            out_flush
);

    rob_entry_t         entries [ROB_SIZE];
    rob_entry_t         head_e;
    rob_entry_t         head1_e;
    rob_entry_t         new_entry;
    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   head1;
    logic [IDX_W-1:0]   tail;
    logic [IDX_W-1:0]   tail_next;
    logic [IDX_W-1:0]   head_adv;
    logic [CNT_W-1:0]   count;
    logic [NUM_CPL-1:0] cpl_hit;
    logic               commit0;
    logic               commit1;
    logic               flush;
    logic               alloc_ok;
    logic               unused_entry_bits;

    rob_ptr_wrap #(.SIZE(ROB_SIZE), .W(IDX_W)) u_head_wrap (
        .ptr      (head),
        .ptr_next (head1)
    );

    rob_ptr_wrap #(.SIZE(ROB_SIZE), .W(IDX_W)) u_tail_wrap (
        .ptr      (tail),
        .ptr_next (tail_next)
    );

`ifdef ROB_DUAL_COMMIT_EN
    logic [IDX_W-1:0] head2;

    rob_ptr_wrap #(.SIZE(ROB_SIZE), .W(IDX_W)) u_head1_wrap (
        .ptr      (head1),
        .ptr_next (head2)
    );

    assign head_adv = commit1 ? head2 : head1;
`else
    assign head_adv = head1;
`endif

    // Commit, flush and allocation decisions all look at pre-edge state, so
    // a completion arriving this cycle cannot make its entry commit until
    // the following cycle. Gating with reset_n keeps every output quiet
    // while reset is held, independent of the inputs.
    always_comb begin
        head_e  = entries[head];
        head1_e = entries[head1];
        commit0 = reset_n & head_e.valid & head_e.complete & ~in_stall;
        flush   = commit0 & has_exception(head_e.exception);
`ifdef ROB_DUAL_COMMIT_EN
        commit1 = commit0 & ~flush & head1_e.valid & head1_e.complete &
                  ~has_exception(head1_e.exception);
`else
        commit1 = 1'b0;
`endif
        alloc_ok = reset_n & in_allocate & ~out_full & ~flush;

        // Completion indices past the last slot or at free slots are dropped.
        for (int p = 0; p < NUM_CPL; p++) begin
            cpl_hit[p] = in_complete[p] && (32'(in_complete_idx[p]) < ROB_SIZE) &&
                         entries[in_complete_idx[p]].valid;
        end

        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.pc         = ROB_XLEN_MAX'(in_PC);
        new_entry.miss_addr  = ROB_XLEN_MAX'(in_addr_miss);
        new_entry.rd         = in_rd;
        new_entry.instr_type = in_instr_type;
    end

    // Commit slot outputs are forced to zero whenever the slot is not ready.
    always_comb begin
        out_ready         = {commit1, commit0};
        out_value[0]      = commit0 ? head_e.value[XLEN-1:0]      : '0;
        out_PC[0]         = commit0 ? head_e.pc[XLEN-1:0]         : '0;
        out_miss_addr[0]  = commit0 ? head_e.miss_addr[XLEN-1:0]  : '0;
        out_rd[0]         = commit0 ? head_e.rd                   : '0;
        out_exception[0]  = commit0 ? head_e.exception            : '0;
        out_instr_type[0] = commit0 ? head_e.instr_type           : '0;
        out_value[1]      = commit1 ? head1_e.value[XLEN-1:0]     : '0;
        out_PC[1]         = commit1 ? head1_e.pc[XLEN-1:0]        : '0;
        out_miss_addr[1]  = commit1 ? head1_e.miss_addr[XLEN-1:0] : '0;
        out_rd[1]         = commit1 ? head1_e.rd                  : '0;
        out_exception[1]  = commit1 ? head1_e.exception           : '0;
        out_instr_type[1] = commit1 ? head1_e.instr_type          : '0;
    end

    assign out_flush     = flush;
    assign out_alloc_ok  = alloc_ok;
    assign out_alloc_idx = tail;
    assign out_count     = count;
    assign out_full      = (count == CNT_W'(ROB_SIZE));
    assign out_empty     = (count == '0);

    // Upper bits of the wide package fields are never read when XLEN < 64.
    assign unused_entry_bits = ^{head_e, head1_e};

    // Completion writes come first and in ascending port order so the
    // highest-numbered port targeting an index is the one that sticks.
    // Commit clears valid afterwards, which is harmless for completions
    // landing on an entry that is retiring in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NUM_CPL; p++) begin
                if (cpl_hit[p]) begin
                    entries[in_complete_idx[p]].complete  <= 1'b1;
                    entries[in_complete_idx[p]].value     <= ROB_XLEN_MAX'(in_complete_value[p]);
                    entries[in_complete_idx[p]].exception <= in_exception[p];
                end
            end
            if (alloc_ok) begin
                entries[tail] <= new_entry;
                tail          <= tail_next;
            end
            if (commit0) begin
                entries[head].valid <= 1'b0;
                head                <= head_adv;
            end
            if (commit1) begin
                entries[head1].valid <= 1'b0;
            end
            count <= count + CNT_W'(alloc_ok) - CNT_W'(commit0) - CNT_W'(commit1);
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer_mc
// Self-checking bench for reorder_buffer_mc (ROB_SIZE=10, NUM_CPL=2, XLEN=32).
// The reference is a program-order queue of in-flight instructions; every
// cycle the expected outputs are derived from its front entries and the
// current inputs. Directed scenarios add hand-computed literal checks, then
// a long randomized run exercises the same model. Honours ROB_DUAL_COMMIT_EN.
// ----------------------------------------------------------------------------
module tb_reorder_buffer_mc;

    localparam int ROB_SIZE = 10;
    localparam int NUM_CPL  = 2;
    localparam int XLEN     = 32;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 4;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic                          alloc;
    logic [XLEN-1:0]               pc;
    logic [XLEN-1:0]               miss;
    logic [4:0]                    rd;
    logic [2:0]                    itype;
    logic [NUM_CPL-1:0]            cpl;
    logic [NUM_CPL-1:0][IDX_W-1:0] cpl_idx;
    logic [NUM_CPL-1:0][XLEN-1:0]  cpl_val;
    logic [NUM_CPL-1:0][2:0]       cpl_exc;
    logic                          stall;

    logic [IDX_W-1:0]              out_alloc_idx;
    logic                          out_alloc_ok;
    logic                          out_full;
    logic                          out_empty;
    logic [CNT_W-1:0]              out_count;
    logic [1:0]                    out_ready;
    logic [1:0][XLEN-1:0]          out_value;
    logic [1:0][XLEN-1:0]          out_PC;
    logic [1:0][XLEN-1:0]          out_miss_addr;
    logic [1:0][4:0]               out_rd;
    logic [1:0][2:0]               out_exception;
    logic [1:0][2:0]               out_instr_type;
    logic                          out_flush;

    always #5 clk = ~clk;

    reorder_buffer_mc #(.ROB_SIZE(ROB_SIZE), .NUM_CPL(NUM_CPL), .XLEN(XLEN)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_allocate       (alloc),
        .in_PC             (pc),
        .in_addr_miss      (miss),
        .in_rd             (rd),
        .in_instr_type     (itype),
        .in_complete       (cpl),
        .in_complete_idx   (cpl_idx),
        .in_complete_value (cpl_val),
        .in_exception      (cpl_exc),
        .in_stall          (stall),
        .out_alloc_idx     (out_alloc_idx),
        .out_alloc_ok      (out_alloc_ok),
        .out_full          (out_full),
        .out_empty         (out_empty),
        .out_count         (out_count),
        .out_ready         (out_ready),
        .out_value         (out_value),
        .out_PC            (out_PC),
        .out_miss_addr     (out_miss_addr),
        .out_rd            (out_rd),
        .out_exception     (out_exception),
        .out_instr_type    (out_instr_type),
        .out_flush         (out_flush)
    );

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] miss;
        logic [31:0] value;
        logic [4:0]  rd;
        logic [2:0]  itype;
        logic [2:0]  exc;
        bit          complete;
    } model_entry_t;

    // In-flight instructions in program order; m_tail is the next slot.
    model_entry_t mq[$];
    int           m_tail;
    int           compared;
    int           mismatched;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        alloc   = 1'b0;
        pc      = '0;
        miss    = '0;
        rd      = '0;
        itype   = '0;
        cpl     = '0;
        cpl_idx = '0;
        cpl_val = '0;
        cpl_exc = '0;
        stall   = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        clearInputs();
    endtask

    // Compare every output against the queue model, then advance the model
    // to the state the coming rising edge must produce.
    task automatic checkOutput();
        int           n;
        bit           c0;
        bit           c1;
        bit           fl;
        bit           aok;
        model_entry_t ne;
        n   = mq.size();
        c0  = (n > 0) && mq[0].complete && !stall;
        fl  = c0 && (mq[0].exc != 3'd0);
        c1  = 1'b0;
`ifdef ROB_DUAL_COMMIT_EN
        c1  = c0 && !fl && (n > 1) && mq[1].complete && (mq[1].exc == 3'd0);
`endif
        aok = alloc && (n < ROB_SIZE) && !fl;

        checkVal("alloc_idx",  out_alloc_idx, m_tail);
        checkVal("alloc_ok",   out_alloc_ok,  aok);
        checkVal("full",       out_full,      n == ROB_SIZE);
        checkVal("empty",      out_empty,     n == 0);
        checkVal("count",      out_count,     n);
        checkVal("flush",      out_flush,     fl);
        checkVal("ready0",     out_ready[0],  c0);
        checkVal("ready1",     out_ready[1],  c1);
        checkVal("value0",     out_value[0],      c0 ? mq[0].value : 32'd0);
        checkVal("pc0",        out_PC[0],         c0 ? mq[0].pc    : 32'd0);
        checkVal("miss0",      out_miss_addr[0],  c0 ? mq[0].miss  : 32'd0);
        checkVal("rd0",        out_rd[0],         c0 ? mq[0].rd    : 5'd0);
        checkVal("exc0",       out_exception[0],  c0 ? mq[0].exc   : 3'd0);
        checkVal("itype0",     out_instr_type[0], c0 ? mq[0].itype : 3'd0);
        checkVal("value1",     out_value[1],      c1 ? mq[1].value : 32'd0);
        checkVal("pc1",        out_PC[1],         c1 ? mq[1].pc    : 32'd0);
        checkVal("miss1",      out_miss_addr[1],  c1 ? mq[1].miss  : 32'd0);
        checkVal("rd1",        out_rd[1],         c1 ? mq[1].rd    : 5'd0);
        checkVal("exc1",       out_exception[1],  c1 ? mq[1].exc   : 3'd0);
        checkVal("itype1",     out_instr_type[1], c1 ? mq[1].itype : 3'd0);

        for (int p = 0; p < NUM_CPL; p++) begin
            if (cpl[p]) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (mq[k].idx == int'(cpl_idx[p])) begin
                        mq[k].complete = 1'b1;
                        mq[k].value    = cpl_val[p];
                        mq[k].exc      = cpl_exc[p];
                    end
                end
            end
        end
        if (fl) begin
            mq.delete();
            m_tail = 0;
        end else begin
            if (c0) void'(mq.pop_front());
            if (c1) void'(mq.pop_front());
            if (aok) begin
                ne.idx      = m_tail;
                ne.pc       = pc;
                ne.miss     = miss;
                ne.value    = '0;
                ne.rd       = rd;
                ne.itype    = itype;
                ne.exc      = '0;
                ne.complete = 1'b0;
                mq.push_back(ne);
                m_tail = (m_tail + 1) % ROB_SIZE;
            end
        end
    endtask

    task automatic settle();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus();
        alloc = ($urandom_range(0, 99) < 55);
        pc    = $urandom;
        miss  = $urandom;
        rd    = 5'($urandom_range(0, 31));
        itype = 3'($urandom_range(0, 7));
        stall = ($urandom_range(0, 99) < 20);
        for (int p = 0; p < NUM_CPL; p++) begin
            cpl[p] = ($urandom_range(0, 99) < 45);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                cpl_idx[p] = IDX_W'(mq[$urandom_range(0, mq.size() - 1)].idx);
            else
                cpl_idx[p] = IDX_W'($urandom_range(0, 15));
            cpl_val[p] = $urandom;
            cpl_exc[p] = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end
    endtask

    task automatic doAlloc(input logic [31:0] a_pc, input logic [4:0] a_rd);
        nextCycle();
        alloc = 1'b1;
        pc    = a_pc;
        miss  = a_pc ^ 32'hFFFF_0000;
        rd    = a_rd;
        itype = 3'd1;
        settle();
    endtask

    // Holds reset with allocate asserted to show outputs stay quiet, then
    // releases it and spends one idle checked cycle.
    task automatic resetDut();
        nextCycle();
        alloc   = 1'b1;
        reset_n = 1'b0;
        #1;
        checkVal("rst_empty",    out_empty,    1'b1);
        checkVal("rst_count",    out_count,    4'd0);
        checkVal("rst_alloc_ok", out_alloc_ok, 1'b0);
        checkVal("rst_full",     out_full,     1'b0);
        checkVal("rst_ready",    out_ready,    2'b00);
        checkVal("rst_flush",    out_flush,    1'b0);
        checkVal("rst_idx",      out_alloc_idx, 4'd0);
        mq.delete();
        m_tail = 0;
        nextCycle();
        reset_n = 1'b1;
        settle();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        m_tail     = 0;
        reset_n    = 1'b0;
        clearInputs();

        // Single allocate, complete, commit.
        resetDut();
        doAlloc(32'h1000, 5'd1);
        checkVal("t1_alloc_idx", out_alloc_idx, 4'd0);
        nextCycle();
        cpl[0] = 1'b1; cpl_idx[0] = 4'd0; cpl_val[0] = 32'hDEADBEEF;
        settle();
        nextCycle();
        settle();
        checkVal("t1_ready0", out_ready[0], 1'b1);
        checkVal("t1_value0", out_value[0], 32'hDEADBEEF);
        checkVal("t1_rd0",    out_rd[0],    5'd1);
        checkVal("t1_pc0",    out_PC[0],    32'h1000);

        // Fill, overflow attempt, and tail wrap.
        resetDut();
        for (int i = 0; i < ROB_SIZE; i++) doAlloc(32'h2000 + 32'(i * 4), 5'(i));
        nextCycle();
        alloc = 1'b1;
        settle();
        checkVal("t2_full",      out_full,      1'b1);
        checkVal("t2_alloc_ok",  out_alloc_ok,  1'b0);
        checkVal("t2_alloc_idx", out_alloc_idx, 4'd0);
        nextCycle();
        cpl[0] = 1'b1; cpl_idx[0] = 4'd0; cpl_val[0] = 32'h100;
        settle();
        nextCycle();
        alloc = 1'b1;
        settle();
        checkVal("t2_commit",       out_ready[0], 1'b1);
        checkVal("t2_full_reject",  out_alloc_ok, 1'b0);
        doAlloc(32'h3000, 5'd20);
        checkVal("t2_wrap_ok",  out_alloc_ok,  1'b1);
        checkVal("t2_wrap_idx", out_alloc_idx, 4'd0);
        checkVal("t2_count",    out_count,     4'd9);

        // Two ports hit idx 2 together; port 1 must win.
        nextCycle();
        cpl = 2'b11;
        cpl_idx[0] = 4'd2; cpl_val[0] = 32'h11;
        cpl_idx[1] = 4'd2; cpl_val[1] = 32'hCAFEBABE;
        settle();
        nextCycle();
        cpl[0] = 1'b1; cpl_idx[0] = 4'd1; cpl_val[0] = 32'h5;
        settle();
        nextCycle();
        settle();
        checkVal("t3_head_val", out_value[0], 32'h5);
`ifdef ROB_DUAL_COMMIT_EN
        checkVal("t3_win_val", out_value[1], 32'hCAFEBABE);
`else
        nextCycle();
        settle();
        checkVal("t3_win_val", out_value[0], 32'hCAFEBABE);
`endif

        // Exception at the head with three younger entries.
        resetDut();
        for (int i = 0; i < 4; i++) doAlloc(32'h4000 + 32'(i), 5'(i + 3));
        nextCycle();
        cpl[0] = 1'b1; cpl_idx[0] = 4'd0; cpl_val[0] = 32'h77; cpl_exc[0] = 3'b001;
        settle();
        nextCycle();
        alloc = 1'b1;
        settle();
        checkVal("t4_flush",    out_flush,        1'b1);
        checkVal("t4_exc0",     out_exception[0], 3'b001);
        checkVal("t4_alloc_ok", out_alloc_ok,     1'b0);
        nextCycle();
        settle();
        checkVal("t4_flush_off", out_flush, 1'b0);
        checkVal("t4_count",     out_count, 4'd0);
        checkVal("t4_empty",     out_empty, 1'b1);

        // Stall, then single or dual commit.
        resetDut();
        doAlloc(32'h5000, 5'd7);
        doAlloc(32'h5004, 5'd8);
        nextCycle();
        cpl = 2'b11;
        cpl_idx[0] = 4'd0; cpl_val[0] = 32'hA0;
        cpl_idx[1] = 4'd1; cpl_val[1] = 32'hA1;
        settle();
        nextCycle();
        stall = 1'b1;
        settle();
        checkVal("t5_stall_rdy", out_ready[0], 1'b0);
        checkVal("t5_stall_cnt", out_count,    4'd2);
        nextCycle();
        settle();
        checkVal("t5_rdy0", out_ready[0], 1'b1);
        nextCycle();
        settle();
`ifdef ROB_DUAL_COMMIT_EN
        checkVal("t5_cnt_after", out_count, 4'd0);
`else
        checkVal("t5_cnt_after", out_count, 4'd1);
`endif

        // Asynchronous reset between edges.
        resetDut();
        doAlloc(32'h6000, 5'd9);
        doAlloc(32'h6004, 5'd10);
        doAlloc(32'h6008, 5'd11);
        checkVal("t6_pre_count", out_count, 4'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("t6_async_count", out_count, 4'd0);
        checkVal("t6_async_empty", out_empty, 1'b1);
        mq.delete();
        m_tail = 0;
        nextCycle();
        reset_n = 1'b1;
        settle();

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            nextCycle();
            applyStimulus();
            settle();
        end

        nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_mc.md
REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 Parameter ROB_SIZE, default 10, number of entries; any value 2..64, not required to be a power of two.
REQ-002 Parameter NUM_CPL, default 2, number of completion ports (port 0 execute, port 1 cache).
REQ-003 Parameter XLEN, default 32, width of PC, value and miss address.
REQ-004 Derived constants: IDX_W = $clog2(ROB_SIZE); CNT_W = $clog2(ROB_SIZE+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_allocate  in  1  request to allocate one entry at the tail.
REQ-008 in_PC, in_addr_miss  in  XLEN each  PC and miss address stored in the allocated entry.
REQ-009 in_rd  in  5; in_instr_type  in  3  destination register and instruction type for the allocated entry.
REQ-010 in_complete  in  [NUM_CPL]x1; in_complete_idx  in  [NUM_CPL]xIDX_W; in_complete_value  in  [NUM_CPL]xXLEN; in_exception  in  [NUM_CPL]x3  completion ports.
REQ-011 in_stall  in  1  blocks commit this cycle.
REQ-012 out_alloc_idx  out  IDX_W  tail index; out_alloc_ok  out  1  allocation accepted this cycle.
REQ-013 out_full, out_empty  out  1 each; out_count  out  CNT_W  number of valid entries.
REQ-014 out_ready  out  [2]x1; out_value, out_PC, out_miss_addr  out  [2]xXLEN; out_rd  out  [2]x5; out_exception, out_instr_type  out  [2]x3  commit slots 0 and 1.
REQ-015 out_flush  out  1  asserted in the cycle the head entry commits with a nonzero exception.

Function
REQ-016 out_alloc_ok = in_allocate & ~out_full & ~out_flush; the entry is written at the tail and the tail advances on the next edge.
REQ-017 The tail and head wrap from ROB_SIZE-1 to 0.
REQ-018 Completion sets the value, the exception and the complete flag of the addressed entry on the next edge; a completion to an invalid entry is ignored.
REQ-019 When several ports target the same index in one cycle, the highest-numbered port wins.
REQ-020 Commit slot 0: out_ready[0] = head valid & complete & ~in_stall; it is combinational from the head entry, and the head frees on the next edge (zero-cycle commit latency).
REQ-021 Commit slot outputs are 0 when the corresponding out_ready is 0.
REQ-022 If the committing head has a nonzero exception, out_flush=1; on the next edge every entry is invalidated, head=tail=0 and count=0.
REQ-023 Allocation in a flush cycle is rejected.
REQ-024 Allocation and commit in the same cycle update count by net zero; when full, allocation is rejected even if a commit occurs that cycle.
REQ-025 Completion and commit of the same entry in the same cycle: commit uses the pre-edge state, so the entry is not committed until complete is set.
REQ-026 out_full = (count==ROB_SIZE); out_empty = (count==0); both are derived from registered state.

Reset
REQ-027 While reset_n=0: all entries invalid, head=tail=count=0.
REQ-028 While reset_n=0: out_empty=1, and all other outputs are 0.
REQ-029 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro ROB_DUAL_COMMIT_EN defined: slot 1 commits head+1 in the same cycle when slot 0 commits, slot 0 has no exception, and head+1 is valid, complete and exception-free; the head then advances by 2, wrapping.
REQ-031 Macro ROB_DUAL_COMMIT_EN undefined: slot 1 outputs are tied to 0 and commit is at most one entry per cycle.

Structure
REQ-032 The shared package rob_pkg holds the rob_entry_t typedef (valid, complete, PC, miss_addr, value, rd, exception, instr_type) and the instruction-type and exception encodings.
REQ-033 Pointer increment with wrap for non-power-of-two sizes is implemented in the sub-module rob_ptr_wrap, used for head, head+1 and tail.

Verification
REQ-034 Allocate PC 0x1000 rd 1, complete idx0 value 0xDEADBEEF on port 0 -> next cycle out_ready[0]=1, out_value[0]=0xDEADBEEF, out_rd[0]=1.
REQ-035 Allocate 10 entries, then 1 more -> out_full=1, the 11th allocation has out_alloc_ok=0, and out_alloc_idx wraps to 0 after the first commit.
REQ-036 Ports 0 and 1 complete idx 2 in the same cycle with 0x11 and 0xCAFEBABE -> the entry holds 0xCAFEBABE.
REQ-037 The head completes with exception 3'b001 while 3 younger entries are valid -> out_flush=1 for one cycle, then out_count=0 and out_empty=1.
REQ-038 in_stall=1 with a completed head -> out_ready[0]=0 and count unchanged; with ROB_DUAL_COMMIT_EN and two completed entries -> both commit in one cycle and count drops by 2.
REQ-039 Assert reset_n=0 mid-stream between clock edges -> out_count=0 and out_empty=1 immediately.
